lct_frame_tx: RTL and testbench



---
 rtl/lct_frame_tx_if.sv | 22 ++
 rtl/lct_frame_tx.sv | 213 +++++++++++++++++++++
 tb/tb_lct_frame_tx.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lct_frame_tx_if.sv
// Byte link from lct_frame_tx toward the TMB interface: valid/ready handshake with a
// control-character flag accompanying each byte.
interface lct_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_k;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_k,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_k,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/lct_frame_tx.sv
// Stamps crossings carrying a valid best track with a BX number, queues them and sends each
// as an 0xBC-headed byte frame. Define LCT_FRAME_TX_CRC_EN to append a CRC-8 byte per frame.
module lct_frame_tx #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned BX_MAX = 3563
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bc0,
  input  logic [6:0]             bw1,
  input  logic [1:0]             bq1,
  input  logic                   fa1,
  input  logic                   bv1,
  input  logic [6:0]             bw2,
  input  logic [1:0]             bq2,
  input  logic                   fa2,
  input  logic                   bv2,
  lct_frame_tx_if.master         tx,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             drop_cnt,
  output logic                   ovf
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);
  localparam logic [11:0] BxLast  = 12'(BX_MAX);
  localparam logic [7:0]  Comma   = 8'hBC;

`ifdef LCT_FRAME_TX_CRC_EN
  typedef enum logic [1:0] {StIdle, StHdr, StData, StCrc} state_e;

  // CRC-8, polynomial 0x07, MSB first.
  function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  logic [7:0] crc_q, crc_d;
`else
  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;
`endif

  // BX counter
  logic [11:0] bxn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bxn_q <= '0;
    end else if (bc0 || (bxn_q == BxLast)) begin
      bxn_q <= '0;
    end else begin
      bxn_q <= bxn_q + 12'd1;
    end
  end

  // Crossing FIFO
  logic [39:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    drop_cnt_q;
  logic          ovf_q;
  logic          push, full, empty, push_ok, pop;
  logic [39:0]   word_in;

  assign word_in = {6'b0, bxn_q, bv2, fa2, bq2, bw2, bv1, fa1, bq1, bw1};
  assign push    = bv1 | bv2;
  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  // Full is judged on the pre-pop count, so a same-edge pop never rescues a push.
  assign push_ok = push & ~full;
  assign count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= word_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (push && full) begin
        ovf_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // Frame FSM
  state_e      state_q, state_d;
  logic [39:0] shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        k_q, k_d, valid_q, valid_d;
  logic        xfer, load_next;

  assign xfer = valid_q & tx.tx_ready;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    data_d    = data_q;
    k_d       = k_q;
    valid_d   = valid_q;
    pop       = 1'b0;
    load_next = 1'b0;
`ifdef LCT_FRAME_TX_CRC_EN
    crc_d     = crc_q;
`endif
    unique case (state_q)
      StIdle: load_next = 1'b1;
      StHdr: begin
        if (xfer) begin
          state_d = StData;
          idx_d   = '0;
          k_d     = 1'b0;
          data_d  = shift_q[39:32];
          shift_d = {shift_q[31:0], 8'h00};
`ifdef LCT_FRAME_TX_CRC_EN
          crc_d   = '0;
`endif
        end
      end
      StData: begin
        if (xfer) begin
`ifdef LCT_FRAME_TX_CRC_EN
          crc_d = crc8(crc_q, data_q);
`endif
          if (idx_q == 3'd4) begin
`ifdef LCT_FRAME_TX_CRC_EN
            state_d = StCrc;
            data_d  = crc8(crc_q, data_q);
`else
            load_next = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            data_d  = shift_q[39:32];
            shift_d = {shift_q[31:0], 8'h00};
          end
        end
      end
`ifdef LCT_FRAME_TX_CRC_EN
      StCrc: begin
        if (xfer) load_next = 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase

    // End of frame (or idle): chain straight into the next header when one is queued.
    if (load_next) begin
      if (!empty) begin
        pop     = 1'b1;
        shift_d = mem[rd_ptr_q];
        state_d = StHdr;
        valid_d = 1'b1;
        k_d     = 1'b1;
        data_d  = Comma;
      end else begin
        state_d = StIdle;
        valid_d = 1'b0;
        k_d     = 1'b0;
        data_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      k_q     <= 1'b0;
      valid_q <= 1'b0;
`ifdef LCT_FRAME_TX_CRC_EN
      crc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      k_q     <= k_d;
      valid_q <= valid_d;
`ifdef LCT_FRAME_TX_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

  assign tx.tx_data  = data_q;
  assign tx.tx_k     = k_q;
  assign tx.tx_valid = valid_q;
  assign fifo_count  = count_q;
  assign drop_cnt    = drop_cnt_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_lct_frame_tx.sv
// Bench for lct_frame_tx: table of track vectors plus corner sequences; a queue of expected
// frame words is checked byte by byte as frames leave the link.
module tb_lct_frame_tx;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned BX_MAX = 3563;
`ifdef LCT_FRAME_TX_CRC_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif

  typedef struct {
    logic [6:0]  bw1;
    logic [1:0]  bq1;
    logic        fa1;
    logic        bv1;
    logic [6:0]  bw2;
    logic [1:0]  bq2;
    logic        fa2;
    logic        bv2;
    logic        push;  // crossing expected to be queued
    logic [21:0] lo;    // expected W[21:0]
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, bc0;
  logic [6:0] bw1, bw2;
  logic [1:0] bq1, bq2;
  logic       fa1, fa2, bv1, bv2;
  logic [4:0] fifo_count;
  logic [7:0] drop_cnt;
  logic       ovf;

  lct_frame_tx_if link();

  lct_frame_tx #(.DEPTH(DEPTH), .BX_MAX(BX_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .bc0        (bc0),
    .bw1        (bw1),
    .bq1        (bq1),
    .fa1        (fa1),
    .bv1        (bv1),
    .bw2        (bw2),
    .bq2        (bq2),
    .fa2        (fa2),
    .bv2        (bv2),
    .tx         (link),
    .fifo_count (fifo_count),
    .drop_cnt   (drop_cnt),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [39:0] sb[$];
  logic [11:0] bxn_m;
  vec_t vecs[5];

  always @(posedge clk) begin
    if (rst || bc0) bxn_m <= 12'd0;
    else if (bxn_m == 12'(BX_MAX)) bxn_m <= 12'd0;
    else bxn_m <= bxn_m + 12'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

`ifdef LCT_FRAME_TX_CRC_EN
  function automatic logic [7:0] crc_model(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ b[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else c = {c[6:0], 1'b0};
    end
    return c;
  endfunction
  logic [7:0] mcrc;
`endif

  // Monitor: one byte per handshake, sampled mid-cycle.
  int          midx = 0;
  logic [39:0] mw;
  logic [7:0]  exp_b;
  always @(negedge clk) begin
    if (rst) begin
      midx = 0;
    end else if (link.tx_valid && link.tx_ready) begin
      if (midx == 0) begin
        check("hdr_byte", {link.tx_k, link.tx_data}, {1'b1, 8'hBC});
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got a frame, expected none");
          mw = '0;
        end else begin
          mw = sb.pop_front();
        end
`ifdef LCT_FRAME_TX_CRC_EN
        mcrc = 8'h00;
`endif
      end else if (midx <= 5) begin
        exp_b = mw[47 - 8*midx -: 8];
        check("data_byte", {link.tx_k, link.tx_data}, {1'b0, exp_b});
`ifdef LCT_FRAME_TX_CRC_EN
        mcrc = crc_model(mcrc, exp_b);
      end else begin
        check("crc_byte", {link.tx_k, link.tx_data}, {1'b0, mcrc});
`endif
      end
      midx = (midx == FRAME_LEN - 1) ? 0 : midx + 1;
    end
  end

  task automatic put(input vec_t v, input bit force_bx, input logic [11:0] bx, input bit keep,
                     output logic [39:0] w);
    bw1 = v.bw1; bq1 = v.bq1; fa1 = v.fa1; bv1 = v.bv1;
    bw2 = v.bw2; bq2 = v.bq2; fa2 = v.fa2; bv2 = v.bv2;
    w = {6'b0, (force_bx ? bx : bxn_m), v.lo};
    if (v.push && keep) sb.push_back(w);
    @(posedge clk); #1;
    bv1 = 1'b0;
    bv2 = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (!(fifo_count == 0 && !link.tx_valid) && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 3000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got busy link, expected idle within 3000 cycles", name);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish by 1000000");
    $fatal(1);
  end

  initial begin
    logic [39:0] w;
    int guard, cnt;

    vecs[0] = '{7'h55, 2'd3, 1'b1, 1'b1, 7'h00, 2'd0, 1'b0, 1'b0, 1'b1, 22'h0007D5};
    vecs[1] = '{7'h7F, 2'd1, 1'b1, 1'b0, 7'h11, 2'd2, 1'b1, 1'b0, 1'b0, 22'h000000};
    vecs[2] = '{7'h00, 2'd0, 1'b0, 1'b0, 7'h12, 2'd1, 1'b0, 1'b1, 1'b1, 22'h249000};
    vecs[3] = '{7'h01, 2'd0, 1'b0, 1'b1, 7'h7F, 2'd3, 1'b1, 1'b1, 1'b1, 22'h3FFC01};
    vecs[4] = '{7'h2A, 2'd2, 1'b0, 1'b1, 7'h33, 2'd0, 1'b0, 1'b0, 1'b1, 22'h019D2A};

    rst = 1'b1; bc0 = 1'b0;
    bw1 = '0; bq1 = '0; fa1 = 1'b0; bv1 = 1'b0;
    bw2 = '0; bq2 = '0; fa2 = 1'b0; bv2 = 1'b0;
    link.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", link.tx_valid, 1'b0);
    check("rst_k", link.tx_k, 1'b0);
    check("rst_data", link.tx_data, 8'h00);
    check("rst_count", fifo_count, 5'd0);
    check("rst_drop", drop_cnt, 8'd0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b0;

    // Single crossing and first-header latency
    repeat (5) @(posedge clk);
    #1;
    put(vecs[0], 1'b0, 12'd0, 1'b1, w);
    check("lat_e0_count", fifo_count, 5'd1);
    check("lat_e0_valid", link.tx_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_e1_hdr", {link.tx_valid, link.tx_k, link.tx_data}, {1'b1, 1'b1, 8'hBC});
    wait_idle("single");

    // Table of track patterns
    for (int i = 0; i < 5; i++) begin
      put(vecs[i], 1'b0, 12'd0, 1'b1, w);
      check("vec_push_count", fifo_count, {4'd0, vecs[i].push});
      wait_idle("vec");
    end

    // BX wrap
    guard = 0;
    while (bxn_m != 12'(BX_MAX) && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("wrap_reached", guard < 5000, 1'b1);
    @(posedge clk); #1;
    put(vecs[4], 1'b1, 12'd0, 1'b1, w);
    wait_idle("wrap");

    // bc0 forces the next BX to zero
    guard = 0;
    while (bxn_m != 12'd100 && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    bc0 = 1'b1;
    @(posedge clk); #1;
    bc0 = 1'b0;
    put(vecs[2], 1'b1, 12'd0, 1'b1, w);
    wait_idle("bc0");

    // Backpressure mid-DATA
    put(vecs[3], 1'b0, 12'd0, 1'b1, w);
    guard = 0;
    while (!(link.tx_valid && !link.tx_k) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    link.tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("stall_hold", {link.tx_valid, link.tx_k, link.tx_data}, {1'b1, 1'b0, w[31:24]});
      @(posedge clk); #1;
    end
    link.tx_ready = 1'b1;
    wait_idle("stall");

    // Overflow: first crossing sits in HDR, DEPTH fill the FIFO, the remaining 2 drop
    link.tx_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      put(vecs[i % 5 == 1 ? 0 : i % 5], 1'b0, 12'd0, (i < DEPTH + 1), w);
    end
    check("ovf_count", fifo_count, 5'(DEPTH));
    check("ovf_drops", drop_cnt, 8'd2);
    check("ovf_flag", ovf, 1'b1);
    link.tx_ready = 1'b1;
    wait_idle("ovf");
    check("ovf_drained", sb.size(), 0);

    // Back-to-back frames
    link.tx_ready = 1'b0;
    put(vecs[0], 1'b0, 12'd0, 1'b1, w);
    put(vecs[3], 1'b0, 12'd0, 1'b1, w);
    put(vecs[4], 1'b0, 12'd0, 1'b1, w);
    repeat (2) @(posedge clk);
    #1;
    link.tx_ready = 1'b1;
    cnt = 0;
    while (link.tx_valid && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("b2b_len", cnt, 3 * FRAME_LEN);
    wait_idle("b2b");

    // Reset in the middle of a frame
    put(vecs[0], 1'b0, 12'd0, 1'b1, w);
    put(vecs[4], 1'b0, 12'd0, 1'b1, w);
    guard = 0;
    while (!(link.tx_valid && !link.tx_k) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    check("midrst_valid", link.tx_valid, 1'b0);
    check("midrst_count", fifo_count, 5'd0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (link.tx_valid) cnt++;
    end
    check("midrst_residual", cnt, 0);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
